capture_scheduler: RTL and testbench

- Sequences the 1-bit frame-capture writer: decides when a capture starts, aligns the start to start-of-frame, and watches for completion with a timeout.
- Arbitrates the captured frame buffer between NUM_READERS pattern-recognition readers (shared read locks) and the writer (exclusive, writer-priority).
- Sits between the video stream control, the frame-capture writer and the downstream readers.

---
 rtl/capture_scheduler.sv | 167 ++++++++++++++++
 tb/tb_capture_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_scheduler.sv
// capture_scheduler: sequences the frame-capture writer (request merge, SOF-aligned
// trigger, completion timeout) and arbitrates the frame buffer between shared
// reader locks and the exclusive, writer-priority capture.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   frame_start_i         one-cycle pulse on the first pixel of a frame
//   sw_req_i              one-cycle software capture request
//   auto_en_i             enables periodic capture
//   auto_period_i         frames between auto captures (0 behaves as 1)
//   capture_trigger_o     one-cycle start pulse to the writer
//   capturing_i           writer is actively capturing
//   capture_complete_i    writer finished-frame pulse
//   rd_req_i / rd_gnt_o   per-reader read-lock request / grant (levels)
//   frame_ready_o         buffer holds a complete, valid frame
//   busy_o                scheduler is not idle
//   timeout_err_o         sticky capture timeout fault
//   err_clear_i           clears the fault and returns to idle
//
// Optional feature macro CAPTURE_STATS_EN adds saturating counters
// frames_captured_o and requests_dropped_o (width CNT_W).
module capture_scheduler #(
    parameter int NUM_READERS    = 4,
    parameter int PERIOD_W       = 8,
    parameter int TIMEOUT_CYCLES = 614400
`ifdef CAPTURE_STATS_EN
    ,
    parameter int CNT_W          = 16
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_start_i,
    input  logic                   sw_req_i,
    input  logic                   auto_en_i,
    input  logic [PERIOD_W-1:0]    auto_period_i,
    output logic                   capture_trigger_o,
    input  logic                   capturing_i,
    input  logic                   capture_complete_i,
    input  logic [NUM_READERS-1:0] rd_req_i,
    output logic [NUM_READERS-1:0] rd_gnt_o,
    output logic                   frame_ready_o,
    output logic                   busy_o,
    output logic                   timeout_err_o,
    input  logic                   err_clear_i
`ifdef CAPTURE_STATS_EN
    ,
    output logic [CNT_W-1:0]       frames_captured_o,
    output logic [CNT_W-1:0]       requests_dropped_o
`endif
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, WAIT_SOF, ARMED, CAPTURE, FAULT} state_t;

    state_t                 state_q, state_d;
    logic                   pending_q, pending_d;
    logic                   frame_ready_q, frame_ready_d;
    logic                   timeout_err_q, timeout_err_d;
    logic [PERIOD_W-1:0]    frm_cnt_q, frm_cnt_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic [NUM_READERS-1:0] rd_gnt_q, rd_gnt_d;
    logic [PERIOD_W:0]      frm_next, period_eff;
    logic                   auto_hit, req_any, trig, grant_ok;

    assign frm_next   = {1'b0, frm_cnt_q} + (PERIOD_W+1)'(1);
    assign period_eff = (auto_period_i == '0) ? (PERIOD_W+1)'(1) : {1'b0, auto_period_i};
    // >= rather than == so a period shortened mid-count still fires promptly
    assign auto_hit   = auto_en_i && frame_start_i && (frm_next >= period_eff);
    assign frm_cnt_d  = (!auto_en_i || auto_hit) ? '0 : frame_start_i ? frm_next[PERIOD_W-1:0] : frm_cnt_q;
    // requests are discarded while faulted; err_clear also drops anything queued
    assign req_any    = (sw_req_i || auto_hit) && (state_q != FAULT);

    // pending=0 already rules out the IDLE->WAIT_SOF transition this cycle
    assign grant_ok = (state_q == IDLE) && frame_ready_q && !pending_q;
    assign rd_gnt_d = rd_req_i & (rd_gnt_q | {NUM_READERS{grant_ok}});

    always_comb begin
        state_d       = state_q;
        trig          = 1'b0;
        pending_d     = pending_q;
        frame_ready_d = frame_ready_q;
        timeout_err_d = timeout_err_q;
        to_cnt_d      = to_cnt_q;
        unique case (state_q)
            IDLE: state_d = (pending_q && rd_gnt_q == '0) ? WAIT_SOF : IDLE;
            WAIT_SOF: begin
                if (frame_start_i) begin
                    trig          = 1'b1;
                    frame_ready_d = 1'b0;
                    pending_d     = 1'b0;
                    to_cnt_d      = '0;
                    state_d       = ARMED;
                end
            end
            ARMED, CAPTURE: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (state_q == CAPTURE && capture_complete_i) begin
                    frame_ready_d = 1'b1;
                    state_d       = IDLE;
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = FAULT;
                end else if (state_q == ARMED && capturing_i) begin
                    state_d = CAPTURE;
                end
            end
            FAULT: begin
                if (err_clear_i) begin
                    timeout_err_d = 1'b0;
                    pending_d     = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // applied last so a request in the trigger cycle queues the next capture
        if (req_any) pending_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pending_q     <= 1'b0;
            frame_ready_q <= 1'b0;
            timeout_err_q <= 1'b0;
            frm_cnt_q     <= '0;
            to_cnt_q      <= '0;
            rd_gnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            frame_ready_q <= frame_ready_d;
            timeout_err_q <= timeout_err_d;
            frm_cnt_q     <= frm_cnt_d;
            to_cnt_q      <= to_cnt_d;
            rd_gnt_q      <= rd_gnt_d;
        end
    end

    assign capture_trigger_o = trig;
    assign rd_gnt_o          = rd_gnt_q;
    assign frame_ready_o     = frame_ready_q;
    assign busy_o            = state_q != IDLE;
    assign timeout_err_o     = timeout_err_q;

`ifdef CAPTURE_STATS_EN
    logic [CNT_W-1:0] frames_q, frames_d, dropped_q, dropped_d;

    assign frames_d  = (state_q == CAPTURE && capture_complete_i && frames_q != '1) ? frames_q + CNT_W'(1) : frames_q;
    // a request merged into an already-pending capture; not counted when it re-queues at the trigger
    assign dropped_d = (req_any && pending_q && !trig && dropped_q != '1) ? dropped_q + CNT_W'(1) : dropped_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_q  <= '0;
            dropped_q <= '0;
        end else begin
            frames_q  <= frames_d;
            dropped_q <= dropped_d;
        end
    end

    assign frames_captured_o  = frames_q;
    assign requests_dropped_o = dropped_q;
`endif
endmodule

// File: tb/tb_capture_scheduler.sv
// tb_capture_scheduler: self-checking bench for capture_scheduler with randomized scenarios.
module tb_capture_scheduler;
    localparam int NR = 4;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0, sw_req = 1'b0, auto_en = 1'b0;
    logic          capturing = 1'b0, capture_complete = 1'b0, err_clear = 1'b0;
    logic [7:0]    auto_period = '0;
    logic [NR-1:0] rd_req = '0;
    logic [NR-1:0] rd_gnt;
    logic          capture_trigger, frame_ready, busy, timeout_err;
    int            checks = 0, passes = 0, trig_cnt = 0;
`ifdef CAPTURE_STATS_EN
    logic [15:0]   frames_captured, requests_dropped;
`endif

    capture_scheduler #(.NUM_READERS(NR), .PERIOD_W(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .frame_start_i(frame_start), .sw_req_i(sw_req),
        .auto_en_i(auto_en), .auto_period_i(auto_period),
        .capture_trigger_o(capture_trigger), .capturing_i(capturing),
        .capture_complete_i(capture_complete),
        .rd_req_i(rd_req), .rd_gnt_o(rd_gnt),
        .frame_ready_o(frame_ready), .busy_o(busy),
        .timeout_err_o(timeout_err), .err_clear_i(err_clear)
`ifdef CAPTURE_STATS_EN
        , .frames_captured_o(frames_captured), .requests_dropped_o(requests_dropped)
`endif
    );

    always #5 clk = ~clk;

    // counts trigger pulses and checks the writer/reader exclusion whenever one fires
    always @(negedge clk) begin
        #2;
        if (capture_trigger === 1'b1) begin
            trig_cnt++;
            checks++;
            if (rd_gnt !== '0) $display("FAIL trig_excl: rd_gnt=%b while triggering, want 0000", rd_gnt); else passes++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic cyc();
        @(negedge clk);
        frame_start = 1'b0; sw_req = 1'b0; capture_complete = 1'b0; err_clear = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic sof();
        cyc();
        frame_start = 1'b1;
    endtask

    // plays the writer from the cycle after a trigger until one cycle after capture_complete
    task automatic write_frame(input int len);
        cyc(); capturing = 1'b1;
        repeat (len) cyc();
        capture_complete = 1'b1;
        cyc(); capturing = 1'b0;
    endtask

    task automatic test_reset();
        idle(3); #1;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passes++;
        checks++; if (frame_ready !== 1'b0) $display("FAIL rst_frame_ready: got %b want 0", frame_ready); else passes++;
        checks++; if (timeout_err !== 1'b0) $display("FAIL rst_err: got %b want 0", timeout_err); else passes++;
        checks++; if (rd_gnt !== '0) $display("FAIL rst_gnt: got %b want 0000", rd_gnt); else passes++;
        cyc(); rst_n = 1'b1;
        idle(3);
        sof(); #1;
        checks++; if (capture_trigger !== 1'b0) $display("FAIL rst_no_trig: got %b want 0", capture_trigger); else passes++;
    endtask

    task automatic test_sw_capture();
        int t0 = trig_cnt;
        cyc(); sw_req = 1'b1;
        cyc(); #1;
        checks++; if (busy !== 1'b0) $display("FAIL sw_busy_early: got %b want 0", busy); else passes++;
        cyc(); #1;
        checks++; if (busy !== 1'b1) $display("FAIL sw_busy_wait: got %b want 1", busy); else passes++;
        idle(6);
        sof(); #1;
        checks++; if (capture_trigger !== 1'b1) $display("FAIL sw_trig: got %b want 1", capture_trigger); else passes++;
        write_frame(8); #1;
        checks++; if (frame_ready !== 1'b1) $display("FAIL sw_frame_ready: got %b want 1", frame_ready); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL sw_busy_done: got %b want 0", busy); else passes++;
        checks++; if (trig_cnt !== t0 + 1) $display("FAIL sw_trig_count: got %0d want %0d", trig_cnt - t0, 1); else passes++;
    endtask

    task automatic test_readers();
        logic [NR-1:0] m1;
        int r;
        int t0 = trig_cnt;
        m1 = NR'($urandom_range(1, (1 << NR) - 2));
        do r = $urandom_range(0, NR - 1); while (m1[r]);
        cyc(); rd_req = m1;
        cyc(); #1;
        checks++; if (rd_gnt !== m1) $display("FAIL rd_shared: got %b want %b", rd_gnt, m1); else passes++;
        sw_req = 1'b1;
        cyc(); rd_req = m1 | (NR'(1) << r); #1;
        checks++; if (rd_gnt !== m1) $display("FAIL rd_hold: got %b want %b", rd_gnt, m1); else passes++;
        cyc(); frame_start = 1'b1; #1;
        checks++; if (capture_trigger !== 1'b0) $display("FAIL rd_no_trig: got %b want 0", capture_trigger); else passes++;
        checks++; if (rd_gnt !== m1) $display("FAIL rd_writer_prio: got %b want %b", rd_gnt, m1); else passes++;
        cyc(); #1;
        checks++; if (busy !== 1'b0) $display("FAIL rd_idle_held: got %b want 0", busy); else passes++;
        cyc(); rd_req = NR'(1) << r;
        cyc(); #1;
        checks++; if (rd_gnt !== '0) $display("FAIL rd_release: got %b want 0000", rd_gnt); else passes++;
        cyc(); rd_req = '0; #1;
        checks++; if (busy !== 1'b1) $display("FAIL rd_wait_sof: got %b want 1", busy); else passes++;
        sof(); #1;
        checks++; if (capture_trigger !== 1'b1) $display("FAIL rd_trig: got %b want 1", capture_trigger); else passes++;
        write_frame(5); #1;
        checks++; if (frame_ready !== 1'b1) $display("FAIL rd_frame_ready: got %b want 1", frame_ready); else passes++;
        checks++; if (trig_cnt !== t0 + 1) $display("FAIL rd_trig_count: got %0d want 1", trig_cnt - t0); else passes++;
        rd_req = m1;
        cyc(); #1;
        checks++; if (rd_gnt !== m1) $display("FAIL rd_regrant: got %b want %b", rd_gnt, m1); else passes++;
        rd_req = '0;
        cyc(); #1;
        checks++; if (rd_gnt !== '0) $display("FAIL rd_drop: got %b want 0000", rd_gnt); else passes++;
    endtask

    task automatic test_auto();
        for (int t = 0; t < 3; t++) begin
            int p_in, p, n, exp_total;
            int t0 = trig_cnt;
            logic exp;
            p_in = (t == 0) ? 0 : (t == 1) ? 3 : $urandom_range(0, 5);
            p = (p_in == 0) ? 1 : p_in;
            n = (t == 1) ? 9 : $urandom_range(6, 12);
            exp_total = (n - 1) / p;
            auto_period = 8'(p_in); auto_en = 1'b1;
            for (int f = 1; f <= n; f++) begin
                idle(4);
                sof(); #1;
                // frame f starts a capture when the previous frame completed a full period
                exp = (f - 1 >= p) && ((f - 1) % p == 0);
                checks++; if (capture_trigger !== exp) $display("FAIL auto_trig p=%0d f=%0d: got %b want %b", p_in, f, capture_trigger, exp); else passes++;
                if (capture_trigger === 1'b1) write_frame(3);
            end
            cyc(); auto_en = 1'b0;
            idle(2); #1;
            if (n % p == 0) begin
                exp_total++;
                checks++; if (busy !== 1'b1) $display("FAIL auto_tail_busy: got %b want 1", busy); else passes++;
                sof(); #1;
                checks++; if (capture_trigger !== 1'b1) $display("FAIL auto_tail_trig: got %b want 1", capture_trigger); else passes++;
                write_frame(3);
            end else begin
                checks++; if (busy !== 1'b0) $display("FAIL auto_tail_idle: got %b want 0", busy); else passes++;
            end
            idle(1);
            checks++; if (trig_cnt - t0 !== exp_total) $display("FAIL auto_count p=%0d n=%0d: got %0d want %0d", p_in, n, trig_cnt - t0, exp_total); else passes++;
        end
    endtask

    task automatic test_back_to_back();
        int k = $urandom_range(2, 4);
        int t0 = trig_cnt;
        for (int i = 0; i < k; i++) begin
            cyc(); sw_req = 1'b1;
            idle($urandom_range(0, 2));
        end
        idle(2);
        sof(); #1;
        checks++; if (capture_trigger !== 1'b1) $display("FAIL b2b_trig1: got %b want 1", capture_trigger); else passes++;
        cyc(); capturing = 1'b1; sw_req = 1'b1;
        idle(3);
        capture_complete = 1'b1;
        cyc(); capturing = 1'b0; #1;
        checks++; if (frame_ready !== 1'b1) $display("FAIL b2b_frame_ready: got %b want 1", frame_ready); else passes++;
        idle(2); #1;
        checks++; if (busy !== 1'b1) $display("FAIL b2b_requeued: got %b want 1", busy); else passes++;
        sof(); #1;
        checks++; if (capture_trigger !== 1'b1) $display("FAIL b2b_trig2: got %b want 1", capture_trigger); else passes++;
        write_frame(3);
        idle(3);
        sof(); #1;
        checks++; if (capture_trigger !== 1'b0) $display("FAIL b2b_no_trig3: got %b want 0", capture_trigger); else passes++;
        idle(1);
        checks++; if (trig_cnt - t0 !== 2) $display("FAIL b2b_count k=%0d: got %0d want 2", k, trig_cnt - t0); else passes++;
    endtask

    task automatic test_timeout();
        cyc(); sw_req = 1'b1;
        idle(3);
        sof(); #1;
        checks++; if (capture_trigger !== 1'b1) $display("FAIL to_trig: got %b want 1", capture_trigger); else passes++;
        cyc(); capturing = 1'b1;
        repeat (TO - 1) cyc();
        #1;
        checks++; if (timeout_err !== 1'b0) $display("FAIL to_early: got %b want 0", timeout_err); else passes++;
        cyc(); #1;
        checks++; if (timeout_err !== 1'b1) $display("FAIL to_err: got %b want 1", timeout_err); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL to_fault_busy: got %b want 1", busy); else passes++;
        checks++; if (frame_ready !== 1'b0) $display("FAIL to_frame_ready: got %b want 0", frame_ready); else passes++;
        capturing = 1'b0;
        cyc(); sw_req = 1'b1;
        idle(3);
        sof(); #1;
        checks++; if (capture_trigger !== 1'b0) $display("FAIL to_fault_trig: got %b want 0", capture_trigger); else passes++;
        cyc(); err_clear = 1'b1;
        cyc(); #1;
        checks++; if (busy !== 1'b0) $display("FAIL to_clear_busy: got %b want 0", busy); else passes++;
        checks++; if (timeout_err !== 1'b0) $display("FAIL to_clear_err: got %b want 0", timeout_err); else passes++;
        idle(3);
        sof(); #1;
        checks++; if (capture_trigger !== 1'b0) $display("FAIL to_req_dropped: got %b want 0", capture_trigger); else passes++;
        idle(1); #1;
        checks++; if (busy !== 1'b0) $display("FAIL to_stay_idle: got %b want 0", busy); else passes++;
    endtask

    task automatic test_async_reset();
        cyc(); sw_req = 1'b1;
        idle(3);
        sof();
        cyc(); capturing = 1'b1; rd_req = '1;
        idle(3); #1;
        checks++; if (busy !== 1'b1) $display("FAIL ar_pre_busy: got %b want 1", busy); else passes++;
        cyc(); #3; rst_n = 1'b0; #1;
        checks++; if (busy !== 1'b0) $display("FAIL ar_busy: got %b want 0", busy); else passes++;
        checks++; if (rd_gnt !== '0) $display("FAIL ar_gnt: got %b want 0000", rd_gnt); else passes++;
        checks++; if ({capture_trigger, frame_ready, timeout_err} !== 3'b000) $display("FAIL ar_outs: got %b want 000", {capture_trigger, frame_ready, timeout_err}); else passes++;
        capturing = 1'b0; rd_req = '0;
        idle(2);
        cyc(); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(3);
            sof(); #1;
            checks++; if (capture_trigger !== 1'b0) $display("FAIL ar_no_trig%0d: got %b want 0", i, capture_trigger); else passes++;
        end
        idle(1); #1;
        checks++; if (busy !== 1'b0) $display("FAIL ar_idle: got %b want 0", busy); else passes++;
    endtask

`ifdef CAPTURE_STATS_EN
    task automatic test_stats();
        int k = $urandom_range(2, 5);
        for (int i = 0; i < k; i++) begin
            cyc(); sw_req = 1'b1;
            idle($urandom_range(0, 2));
        end
        idle(2);
        sof(); #1;
        checks++; if (capture_trigger !== 1'b1) $display("FAIL st_trig: got %b want 1", capture_trigger); else passes++;
        write_frame(3); #1;
        checks++; if (frames_captured !== 16'd1) $display("FAIL st_frames: got %0d want 1", frames_captured); else passes++;
        checks++; if (requests_dropped !== 16'(k - 1)) $display("FAIL st_dropped: got %0d want %0d", requests_dropped, k - 1); else passes++;
    endtask
`endif

    initial begin
        test_reset();
        test_sw_capture();
        test_readers();
        test_auto();
        test_back_to_back();
        test_timeout();
        test_async_reset();
`ifdef CAPTURE_STATS_EN
        test_stats();
`endif
        idle(2);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
